// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory req/ack handshake with timeout, MEM/WB register.
// Optional feature macro: MEM_OVF_TRAP_EN (overflowing entries skip memory and retire without RegWrite).
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_MEM_valid,
  input  logic [31:0] i_MEM_data_ALUOut,
  input  logic        i_MEM_data_Overflow,
  input  logic [31:0] i_MEM_data_RTData,
  input  logic [4:0]  i_WB_data_RegAddrW,
  input  logic        i_MEM_ctrl_MemRead,
  input  logic        i_MEM_ctrl_MemWrite,
  input  logic        i_WB_ctrl_Mem2Reg,
  input  logic        i_WB_ctrl_RegWrite,
  input  logic        i_MEM_flush,
  output logic        o_MEM_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_WB_valid,
  output logic [31:0] o_WB_data_ALUOut,
  output logic [31:0] o_WB_data_MemData,
  output logic [4:0]  o_WB_data_RegAddrW,
  output logic        o_WB_ctrl_Mem2Reg,
  output logic        o_WB_ctrl_RegWrite,
  output logic        o_MEM_err
`ifdef MEM_OVF_TRAP_EN
  ,
  output logic        o_MEM_exc_Overflow
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_e;

  logic        exm_valid_q;
  logic [31:0] exm_alu_q, exm_rt_q;
  logic [4:0]  exm_rd_q;
  logic        exm_mr_q, exm_mw_q, exm_m2r_q, exm_rw_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_mem_q, wb_mem_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_m2r_q, wb_m2r_d;
  logic        wb_rw_q, wb_rw_d;

  logic live, mem_op, is_load, misaligned, trap;
  logic req, stall, retire, retire_trap;

  // A flush kills the held entry at once; the handshake itself is never cut short by it.
  assign live       = exm_valid_q & ~i_MEM_flush;
  assign mem_op     = exm_mr_q | exm_mw_q;
  assign is_load    = exm_mr_q & ~exm_mw_q;
  assign misaligned = exm_alu_q[1:0] != 2'b00;

`ifdef MEM_OVF_TRAP_EN
  logic exm_ovf_q;
  logic exc_q;
  assign trap               = exm_ovf_q;
  assign o_MEM_exc_Overflow = exc_q;
`else
  logic unused_ovf;
  assign unused_ovf = i_MEM_data_Overflow;
  assign trap       = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req         = 1'b0;
    stall       = 1'b0;
    retire      = 1'b0;
    retire_trap = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (live) begin
          if (trap) begin
            retire_trap = 1'b1;
          end else if (!mem_op) begin
            retire = 1'b1;
          end else if (misaligned) begin
            err_d = 1'b1;
          end else begin
            req = 1'b1;
            if (i_dmem_ack) begin
              retire = 1'b1;
            end else begin
              stall   = 1'b1;
              cnt_d   = CNT_W'(1);
              state_d = (TIMEOUT == 1) ? S_ABORT : S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (i_dmem_ack) begin
          retire  = live;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          // The request has been up for TIMEOUT cycles once the counter reaches TIMEOUT.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wb_valid_d = retire | retire_trap;
    wb_rw_d    = retire & exm_rw_q;
    wb_alu_d   = wb_alu_q;
    wb_mem_d   = wb_mem_q;
    wb_rd_d    = wb_rd_q;
    wb_m2r_d   = wb_m2r_q;
    if (retire | retire_trap) begin
      wb_alu_d = exm_alu_q;
      wb_rd_d  = exm_rd_q;
      wb_m2r_d = exm_m2r_q;
      wb_mem_d = (retire && is_load) ? i_dmem_rdata : 32'h0;
    end
  end

  // NOTE: datapath registers are reset too, so every output reads 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid_q <= 1'b0;
      exm_alu_q   <= '0;
      exm_rt_q    <= '0;
      exm_rd_q    <= '0;
      exm_mr_q    <= 1'b0;
      exm_mw_q    <= 1'b0;
      exm_m2r_q   <= 1'b0;
      exm_rw_q    <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_alu_q    <= '0;
      wb_mem_q    <= '0;
      wb_rd_q     <= '0;
      wb_m2r_q    <= 1'b0;
      wb_rw_q     <= 1'b0;
`ifdef MEM_OVF_TRAP_EN
      exm_ovf_q   <= 1'b0;
      exc_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      if (!stall) begin
        exm_valid_q <= i_MEM_valid;
        exm_alu_q   <= i_MEM_data_ALUOut;
        exm_rt_q    <= i_MEM_data_RTData;
        exm_rd_q    <= i_WB_data_RegAddrW;
        exm_mr_q    <= i_MEM_ctrl_MemRead;
        exm_mw_q    <= i_MEM_ctrl_MemWrite;
        exm_m2r_q   <= i_WB_ctrl_Mem2Reg;
        exm_rw_q    <= i_WB_ctrl_RegWrite;
`ifdef MEM_OVF_TRAP_EN
        exm_ovf_q   <= i_MEM_data_Overflow;
`endif
      end else begin
        exm_valid_q <= exm_valid_q & ~i_MEM_flush;
      end
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wb_valid_q <= wb_valid_d;
      wb_alu_q   <= wb_alu_d;
      wb_mem_q   <= wb_mem_d;
      wb_rd_q    <= wb_rd_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rw_q    <= wb_rw_d;
`ifdef MEM_OVF_TRAP_EN
      exc_q      <= retire_trap;
`endif
    end
  end

  assign o_MEM_stall        = stall;
  assign o_dmem_req         = req;
  assign o_dmem_we          = exm_mw_q;
  assign o_dmem_addr        = exm_alu_q;
  assign o_dmem_wdata       = exm_rt_q;
  assign o_WB_valid         = wb_valid_q;
  assign o_WB_data_ALUOut   = wb_alu_q;
  assign o_WB_data_MemData  = wb_mem_q;
  assign o_WB_data_RegAddrW = wb_rd_q;
  assign o_WB_ctrl_Mem2Reg  = wb_m2r_q;
  assign o_WB_ctrl_RegWrite = wb_rw_q;
  assign o_MEM_err          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: inputs driven on the falling edge, outputs checked away from the rising edge.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk, rst;
  logic        i_MEM_valid;
  logic [31:0] i_MEM_data_ALUOut;
  logic        i_MEM_data_Overflow;
  logic [31:0] i_MEM_data_RTData;
  logic [4:0]  i_WB_data_RegAddrW;
  logic        i_MEM_ctrl_MemRead, i_MEM_ctrl_MemWrite;
  logic        i_WB_ctrl_Mem2Reg, i_WB_ctrl_RegWrite;
  logic        i_MEM_flush;
  logic        o_MEM_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_WB_valid;
  logic [31:0] o_WB_data_ALUOut, o_WB_data_MemData;
  logic [4:0]  o_WB_data_RegAddrW;
  logic        o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite;
  logic        o_MEM_err;
`ifdef MEM_OVF_TRAP_EN
  logic        o_MEM_exc_Overflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_MEM_valid         (i_MEM_valid),
    .i_MEM_data_ALUOut   (i_MEM_data_ALUOut),
    .i_MEM_data_Overflow (i_MEM_data_Overflow),
    .i_MEM_data_RTData   (i_MEM_data_RTData),
    .i_WB_data_RegAddrW  (i_WB_data_RegAddrW),
    .i_MEM_ctrl_MemRead  (i_MEM_ctrl_MemRead),
    .i_MEM_ctrl_MemWrite (i_MEM_ctrl_MemWrite),
    .i_WB_ctrl_Mem2Reg   (i_WB_ctrl_Mem2Reg),
    .i_WB_ctrl_RegWrite  (i_WB_ctrl_RegWrite),
    .i_MEM_flush         (i_MEM_flush),
    .o_MEM_stall         (o_MEM_stall),
    .o_dmem_req          (o_dmem_req),
    .o_dmem_we           (o_dmem_we),
    .o_dmem_addr         (o_dmem_addr),
    .o_dmem_wdata        (o_dmem_wdata),
    .i_dmem_ack          (i_dmem_ack),
    .i_dmem_rdata        (i_dmem_rdata),
    .o_WB_valid          (o_WB_valid),
    .o_WB_data_ALUOut    (o_WB_data_ALUOut),
    .o_WB_data_MemData   (o_WB_data_MemData),
    .o_WB_data_RegAddrW  (o_WB_data_RegAddrW),
    .o_WB_ctrl_Mem2Reg   (o_WB_ctrl_Mem2Reg),
    .o_WB_ctrl_RegWrite  (o_WB_ctrl_RegWrite),
    .o_MEM_err           (o_MEM_err)
`ifdef MEM_OVF_TRAP_EN
    ,
    .o_MEM_exc_Overflow  (o_MEM_exc_Overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_MEM_valid         = 1'b0;
    i_MEM_data_ALUOut   = 32'h0;
    i_MEM_data_Overflow = 1'b0;
    i_MEM_data_RTData   = 32'h0;
    i_WB_data_RegAddrW  = 5'd0;
    i_MEM_ctrl_MemRead  = 1'b0;
    i_MEM_ctrl_MemWrite = 1'b0;
    i_WB_ctrl_Mem2Reg   = 1'b0;
    i_WB_ctrl_RegWrite  = 1'b0;
    i_MEM_flush         = 1'b0;
    i_dmem_ack          = 1'b0;
    i_dmem_rdata        = 32'h0;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic ovf);
    i_MEM_valid         = 1'b1;
    i_MEM_data_ALUOut   = alu;
    i_MEM_data_RTData   = rt;
    i_WB_data_RegAddrW  = rd;
    i_MEM_ctrl_MemRead  = mr;
    i_MEM_ctrl_MemWrite = mw;
    i_WB_ctrl_Mem2Reg   = m2r;
    i_WB_ctrl_RegWrite  = rw;
    i_MEM_data_Overflow = ovf;
  endtask

  initial begin
    int    req_cycles;
    int    stall_gaps;
    logic  exp_rw;
    logic  exp_req;

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req", o_dmem_req, 0);
    check("rst_stall", o_MEM_stall, 0);
    check("rst_wb_valid", o_WB_valid, 0);
    check("rst_wb_rw", o_WB_ctrl_RegWrite, 0);
    check("rst_err", o_MEM_err, 0);
    check("rst_addr", o_dmem_addr, 0);

    // ALU op passes through in one cycle, no memory traffic
    issue(32'h1234, 32'h0, 5'd5, 0, 0, 0, 1, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("alu_req", o_dmem_req, 0);
    check("alu_stall", o_MEM_stall, 0);
    @(negedge clk);
    check("alu_wb_valid", o_WB_valid, 1);
    check("alu_wb_alu", o_WB_data_ALUOut, 32'h1234);
    check("alu_wb_rd", o_WB_data_RegAddrW, 5);
    check("alu_wb_rw", o_WB_ctrl_RegWrite, 1);

    // Load acked in the request cycle: no stall
    issue(32'h100, 32'h0, 5'd7, 1, 0, 1, 1, 0);
    @(negedge clk);
    idle_inputs();
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld_req", o_dmem_req, 1);
    check("ld_we", o_dmem_we, 0);
    check("ld_addr", o_dmem_addr, 32'h100);
    check("ld_stall", o_MEM_stall, 0);
    @(negedge clk);
    i_dmem_ack = 1'b0;
    check("ld_wb_valid", o_WB_valid, 1);
    check("ld_wb_mem", o_WB_data_MemData, 32'hDEADBEEF);
    check("ld_wb_m2r", o_WB_ctrl_Mem2Reg, 1);
    check("ld_wb_rd", o_WB_data_RegAddrW, 7);

    // Load flushed while waiting: req held to ack, retires as bubble, no error
    issue(32'h200, 32'h0, 5'd3, 1, 0, 1, 1, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("fl_stall_idle", o_MEM_stall, 1);
    @(negedge clk);
    i_MEM_flush = 1'b1;
    #1;
    check("fl_req_at_flush", o_dmem_req, 1);
    check("fl_stall_at_flush", o_MEM_stall, 1);
    @(negedge clk);
    i_MEM_flush = 1'b0;
    check("fl_wb_valid_wait", o_WB_valid, 0);
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h12345678;
    #1;
    check("fl_req_ack", o_dmem_req, 1);
    check("fl_stall_ack", o_MEM_stall, 0);
    @(negedge clk);
    i_dmem_ack = 1'b0;
    check("fl_wb_valid", o_WB_valid, 0);
    check("fl_wb_rw", o_WB_ctrl_RegWrite, 0);
    check("fl_wb_mem_hold", o_WB_data_MemData, 32'hDEADBEEF);
    check("fl_err", o_MEM_err, 0);

    // Store acked after 3 stall cycles; upstream holds the next ALU op meanwhile
    issue(32'h104, 32'hA5A5A5A5, 5'd0, 0, 1, 0, 0, 0);
    @(negedge clk);
    issue(32'h77, 32'h0, 5'd9, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_req", o_dmem_req, 1);
      check("st_stall", o_MEM_stall, 1);
      check("st_addr", o_dmem_addr, 32'h104);
      check("st_wdata", o_dmem_wdata, 32'hA5A5A5A5);
      check("st_we", o_dmem_we, 1);
      @(negedge clk);
    end
    i_dmem_ack = 1'b1;
    #1;
    check("st_ack_req", o_dmem_req, 1);
    check("st_ack_stall", o_MEM_stall, 0);
    @(negedge clk);
    idle_inputs();
    check("st_wb_valid", o_WB_valid, 1);
    check("st_wb_rw", o_WB_ctrl_RegWrite, 0);
    check("st_wb_mem", o_WB_data_MemData, 32'h0);
    check("st_wb_alu", o_WB_data_ALUOut, 32'h104);
    #1;
    check("held_req", o_dmem_req, 0);
    @(negedge clk);
    check("held_wb_valid", o_WB_valid, 1);
    check("held_wb_alu", o_WB_data_ALUOut, 32'h77);
    check("held_wb_rd", o_WB_data_RegAddrW, 9);

    // MemRead and MemWrite together behave as a store
    issue(32'h108, 32'hCAFEF00D, 5'd2, 1, 1, 0, 1, 0);
    @(negedge clk);
    idle_inputs();
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h55555555;
    #1;
    check("rw_we", o_dmem_we, 1);
    check("rw_wdata", o_dmem_wdata, 32'hCAFEF00D);
    check("rw_stall", o_MEM_stall, 0);
    @(negedge clk);
    i_dmem_ack = 1'b0;
    check("rw_wb_valid", o_WB_valid, 1);
    check("rw_wb_mem", o_WB_data_MemData, 32'h0);

    // Overflowing ALU op and store
`ifdef MEM_OVF_TRAP_EN
    exp_rw  = 1'b0;
    exp_req = 1'b0;
`else
    exp_rw  = 1'b1;
    exp_req = 1'b1;
`endif
    issue(32'h80000000, 32'h0, 5'd4, 0, 0, 0, 1, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ovf_alu_req", o_dmem_req, 0);
    @(negedge clk);
    check("ovf_alu_wb_valid", o_WB_valid, 1);
    check("ovf_alu_wb_rw", o_WB_ctrl_RegWrite, {31'h0, exp_rw});
    check("ovf_alu_wb_alu", o_WB_data_ALUOut, 32'h80000000);
`ifdef MEM_OVF_TRAP_EN
    check("ovf_exc_pulse", o_MEM_exc_Overflow, 1);
`endif
    issue(32'h10C, 32'h1, 5'd0, 0, 1, 0, 0, 1);
    @(negedge clk);
    idle_inputs();
`ifdef MEM_OVF_TRAP_EN
    check("ovf_exc_end", o_MEM_exc_Overflow, 0);
`endif
    i_dmem_ack = 1'b1;
    #1;
    check("ovf_st_req", o_dmem_req, {31'h0, exp_req});
    @(negedge clk);
    i_dmem_ack = 1'b0;
    check("ovf_st_wb_valid", o_WB_valid, 1);
    check("ovf_st_wb_rw", o_WB_ctrl_RegWrite, 0);

    // Load never acked: req up TIMEOUT cycles, then abort with bubble and sticky error
    issue(32'h300, 32'h0, 5'd8, 1, 0, 1, 1, 0);
    @(negedge clk);
    idle_inputs();
    req_cycles = 0;
    stall_gaps = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!o_dmem_req) break;
      req_cycles++;
      if (!o_MEM_stall) stall_gaps++;
      @(negedge clk);
    end
    check("to_req_cycles", req_cycles, TIMEOUT);
    check("to_stall_gaps", stall_gaps, 0);
    check("to_abort_stall", o_MEM_stall, 0);
    @(negedge clk);
    check("to_wb_valid", o_WB_valid, 0);
    check("to_wb_rw", o_WB_ctrl_RegWrite, 0);
    check("to_err", o_MEM_err, 1);
    issue(32'h42, 32'h0, 5'd1, 0, 0, 0, 1, 0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("rec_wb_valid", o_WB_valid, 1);
    check("rec_wb_alu", o_WB_data_ALUOut, 32'h42);
    check("rec_err_sticky", o_MEM_err, 1);

    // Error clears only on reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_err", o_MEM_err, 0);
    check("rst2_wb_valid", o_WB_valid, 0);

    // Misaligned load: no request, bubble, error
    issue(32'h102, 32'h0, 5'd6, 1, 0, 1, 1, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mis_req", o_dmem_req, 0);
    check("mis_stall", o_MEM_stall, 0);
    @(negedge clk);
    check("mis_wb_valid", o_WB_valid, 0);
    check("mis_wb_rw", o_WB_ctrl_RegWrite, 0);
    check("mis_err", o_MEM_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
